// File: rtl/timer0_pkg.sv
// Shared constants and state encoding for the Timer/Counter0 register write arbiter.
`default_nettype none

package timer0_pkg;

  localparam logic [1:0] TMR_ADDR_OCR0A  = 2'd0;
  localparam logic [1:0] TMR_ADDR_OCR0B  = 2'd1;
  localparam logic [1:0] TMR_ADDR_TCCR0A = 2'd2;
  localparam logic [1:0] TMR_ADDR_TCCR0B = 2'd3;

  // Clock-select field of TCCR0B; zero means the timer clock is stopped.
  localparam int CS_MSB = 2;
  localparam int CS_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STOP    = 2'd1,
    ST_MODE    = 2'd2,
    ST_RESTART = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/timer0_reg_arbiter_rr_arbiter.sv
// Round-robin grant: first valid requester at or after (ptr+1) mod NUM_REQ, one-hot output.
`default_nettype none

module rr_arbiter
  import timer0_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/timer0_reg_arbiter.sv
// Round-robin write-port arbiter for Timer/Counter0 with register shadows.
// TIMER0_SAFE_MODE_SWITCH_EN: stop the timer clock around TCCR0A rewrites.
`default_nettype none

module timer0_reg_arbiter
  import timer0_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           timer_wdata,
  output logic                 ocr0a_wren,
  output logic                 ocr0b_wren,
  output logic                 tccr0a_wren,
  output logic                 tccr0b_wren,
  output logic [7:0]           shadow_ocr0a,
  output logic [7:0]           shadow_ocr0b,
  output logic [7:0]           shadow_tccr0a,
  output logic [7:0]           shadow_tccr0b,
  output logic                 busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic [1:0]         sel_addr;
  logic [7:0]         sel_data;
  logic               accept;
`ifdef TIMER0_SAFE_MODE_SWITCH_EN
  logic [7:0]         mode_data;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  // Ready is also masked during reset so nothing looks accepted while held.
  assign req_ready = (state == ST_IDLE && reset_n) ? grant : '0;
  assign accept    = |req_ready;

  always_comb begin
    grant_idx = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = PTR_W'(i);
        sel_addr  = req_addr[2*i +: 2];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      timer_wdata   <= '0;
      ocr0a_wren    <= 1'b0;
      ocr0b_wren    <= 1'b0;
      tccr0a_wren   <= 1'b0;
      tccr0b_wren   <= 1'b0;
      shadow_ocr0a  <= '0;
      shadow_ocr0b  <= '0;
      shadow_tccr0a <= '0;
      shadow_tccr0b <= '0;
      busy          <= 1'b0;
`ifdef TIMER0_SAFE_MODE_SWITCH_EN
      mode_data     <= '0;
`endif
    end else begin
      ocr0a_wren  <= 1'b0;
      ocr0b_wren  <= 1'b0;
      tccr0a_wren <= 1'b0;
      tccr0b_wren <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            ptr         <= grant_idx;
            timer_wdata <= sel_data;
            case (sel_addr)
              TMR_ADDR_OCR0A: begin
                ocr0a_wren   <= 1'b1;
                shadow_ocr0a <= sel_data;
              end
              TMR_ADDR_OCR0B: begin
                ocr0b_wren   <= 1'b1;
                shadow_ocr0b <= sel_data;
              end
              TMR_ADDR_TCCR0A: begin
`ifdef TIMER0_SAFE_MODE_SWITCH_EN
                if (shadow_tccr0b[CS_MSB:CS_LSB] != '0) begin
                  // The STOP strobe leaves on this edge; the mode write follows.
                  mode_data   <= sel_data;
                  tccr0b_wren <= 1'b1;
                  timer_wdata <= {shadow_tccr0b[7:CS_MSB+1], {(CS_MSB-CS_LSB+1){1'b0}}};
                  busy        <= 1'b1;
                  state       <= ST_STOP;
                end else begin
                  tccr0a_wren   <= 1'b1;
                  shadow_tccr0a <= sel_data;
                end
`else
                tccr0a_wren   <= 1'b1;
                shadow_tccr0a <= sel_data;
`endif
              end
              default: begin
                tccr0b_wren   <= 1'b1;
                shadow_tccr0b <= sel_data;
              end
            endcase
          end
        end
`ifdef TIMER0_SAFE_MODE_SWITCH_EN
        ST_STOP: begin
          tccr0a_wren   <= 1'b1;
          timer_wdata   <= mode_data;
          shadow_tccr0a <= mode_data;
          state         <= ST_MODE;
        end
        ST_MODE: begin
          tccr0b_wren <= 1'b1;
          timer_wdata <= shadow_tccr0b;
          state       <= ST_RESTART;
        end
        ST_RESTART: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_timer0_reg_arbiter.sv
// Randomized bench for timer0_reg_arbiter against a queue-based behavioural model.
`default_nettype none

module tb_timer0_reg_arbiter;

  localparam int N = 2;
`ifdef TIMER0_SAFE_MODE_SWITCH_EN
  localparam bit SAFE = 1'b1;
`else
  localparam bit SAFE = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [2*N-1:0] req_addr;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [7:0]     timer_wdata;
  logic           ocr0a_wren, ocr0b_wren, tccr0a_wren, tccr0b_wren;
  logic [7:0]     shadow_ocr0a, shadow_ocr0b, shadow_tccr0a, shadow_tccr0b;
  logic           busy;

  timer0_reg_arbiter #(.NUM_REQ(N)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .timer_wdata   (timer_wdata),
    .ocr0a_wren    (ocr0a_wren),
    .ocr0b_wren    (ocr0b_wren),
    .tccr0a_wren   (tccr0a_wren),
    .tccr0b_wren   (tccr0b_wren),
    .shadow_ocr0a  (shadow_ocr0a),
    .shadow_ocr0b  (shadow_ocr0b),
    .shadow_tccr0a (shadow_tccr0a),
    .shadow_tccr0b (shadow_tccr0b),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  // Model: each queued op is what the timer sees in one future cycle (kind -1 = no strobe).
  typedef struct {
    int       kind;
    logic [7:0] data;
    bit       upd;
  } op_t;

  op_t        q[$];
  int         m_ptr;
  logic [7:0] m_sh [4];
  logic [3:0] m_wren;
  logic [7:0] m_wdata;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int grant_of(input logic [N-1:0] v);
    for (int i = 1; i <= N; i++) begin
      if (v[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic [N-1:0] v, input logic [2*N-1:0] a,
                            input logic [8*N-1:0] d, input bit rn);
    op_t op;
    int g;
    int ad;
    logic [7:0] dt;
    m_wren = '0;
    if (!rn) begin
      q.delete();
      m_ptr   = 0;
      m_wdata = '0;
      for (int k = 0; k < 4; k++) m_sh[k] = '0;
    end else if (q.size() > 0) begin
      op = q.pop_front();
      if (op.kind >= 0) begin
        m_wren[op.kind] = 1'b1;
        m_wdata = op.data;
        if (op.upd) m_sh[op.kind] = op.data;
      end
    end else begin
      g = grant_of(v);
      if (g >= 0) begin
        m_ptr = g;
        ad = int'(a[2*g +: 2]);
        dt = d[8*g +: 8];
        if (SAFE && ad == 2 && m_sh[3][2:0] != 3'd0) begin
          m_wren[3] = 1'b1;
          m_wdata   = m_sh[3] & 8'hF8;
          q.push_back('{kind: 2, data: dt, upd: 1'b1});
          q.push_back('{kind: 3, data: m_sh[3], upd: 1'b0});
          q.push_back('{kind: -1, data: 8'h00, upd: 1'b0});
        end else begin
          m_wren[ad] = 1'b1;
          m_wdata    = dt;
          m_sh[ad]   = dt;
        end
      end
    end
  endtask

  task automatic step(input logic [N-1:0] v, input logic [2*N-1:0] a,
                      input logic [8*N-1:0] d, input bit rn);
    logic [N-1:0] er;
    int g;
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    reset_n   = rn;
    #1;
    er = '0;
    if (rn && q.size() == 0) begin
      g = grant_of(v);
      if (g >= 0) er[g] = 1'b1;
    end
    check("ready", 32'(req_ready), 32'(er));
    @(posedge clock);
    model_edge(v, a, d, rn);
    #1;
    check("wren", 32'({tccr0b_wren, tccr0a_wren, ocr0b_wren, ocr0a_wren}), 32'(m_wren));
    if (m_wren != 4'd0) check("wdata", 32'(timer_wdata), 32'(m_wdata));
    check("sh_ocr0a", 32'(shadow_ocr0a), 32'(m_sh[0]));
    check("sh_ocr0b", 32'(shadow_ocr0b), 32'(m_sh[1]));
    check("sh_tccr0a", 32'(shadow_tccr0a), 32'(m_sh[2]));
    check("sh_tccr0b", 32'(shadow_tccr0b), 32'(m_sh[3]));
    check("busy", 32'(busy), 32'(q.size() > 0));
  endtask

  initial begin
    m_ptr = 0;
    m_wdata = '0;
    m_wren = '0;
    for (int k = 0; k < 4; k++) m_sh[k] = '0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    reset_n   = 1'b0;
    #1;

    // Reset held with valid high
    for (int k = 0; k < 3; k++) step(2'b11, 4'b0000, 16'hFFFF, 1'b0);
    check("rst_wdata", 32'(timer_wdata), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // Simultaneous requests: req1 first from pointer 0
    step(2'b11, {2'd1, 2'd0}, {8'h80, 8'h40}, 1'b1);
    check("sim_b_wren", 32'(ocr0b_wren), 32'h1);
    check("sim_b_data", 32'(timer_wdata), 32'h80);
    step(2'b01, {2'd1, 2'd0}, {8'h80, 8'h40}, 1'b1);
    check("sim_a_wren", 32'(ocr0a_wren), 32'h1);
    check("sim_sh_a", 32'(shadow_ocr0a), 32'h40);
    check("sim_sh_b", 32'(shadow_ocr0b), 32'h80);

    // Back-to-back throughput
    for (int k = 1; k <= 4; k++) begin
      step(2'b01, 4'b0000, {8'h00, 8'(k)}, 1'b1);
      check("b2b_wren", 32'(ocr0a_wren), 32'h1);
      check("b2b_data", 32'(timer_wdata), 32'(k));
    end

    // Safe switch with competitors held valid during the sequence
    step(2'b01, {2'd0, 2'd3}, {8'h00, 8'h03}, 1'b1);
    step(2'b01, {2'd0, 2'd2}, {8'h00, 8'h83}, 1'b1);
    for (int k = 0; k < 3; k++) step(2'b11, {2'd1, 2'd1}, {8'h11, 8'h22}, 1'b1);
    step(2'b00, 4'b0000, 16'h0000, 1'b1);

    // Switch while stopped
    step(2'b01, {2'd0, 2'd3}, {8'h00, 8'h00}, 1'b1);
    step(2'b01, {2'd0, 2'd2}, {8'h00, 8'h02}, 1'b1);
    check("stopped_busy", 32'(busy), 32'h0);
    step(2'b00, 4'b0000, 16'h0000, 1'b1);

    // Reset during MODE
    step(2'b01, {2'd0, 2'd3}, {8'h00, 8'h05}, 1'b1);
    step(2'b01, {2'd0, 2'd2}, {8'h00, 8'hAA}, 1'b1);
    step(2'b00, 4'b0000, 16'h0000, 1'b1);
    step(2'b00, 4'b0000, 16'h0000, 1'b0);
    step(2'b00, 4'b0000, 16'h0000, 1'b1);
    check("mid_rst_sh_a", 32'(shadow_tccr0a), 32'h0);
    check("mid_rst_sh_b", 32'(shadow_tccr0b), 32'h0);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      step(N'($urandom), (2*N)'($urandom), (8*N)'($urandom), ($urandom_range(0, 59) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
